lift_floor_controller: RTL and testbench



---
 rtl/lift_floor_controller.sv | 185 ++++++++++++++++++
 tb/tb_lift_floor_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_floor_controller.sv
`default_nettype none
// =============================================================================
// Module   : lift_floor_controller
// Brief    : Lift car model with collective up/down scheduling, travel/door
//            timers and a 7-segment floor indicator. Optional LIFT_MOVE_BLINK_EN
//            blanks the digit for the second half of every floor's travel.
// Revision : 1.0 - initial release
// =============================================================================
module lift_floor_controller #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floor,
    output logic [6:0]            seg,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int c_TRAVEL_W = $clog2(TRAVEL_CYCLES);
    localparam int c_DOOR_W   = $clog2(DOOR_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    state_t                  r_state,   w_state_nxt;
    logic                    r_dir_up,  w_dir_nxt;
    logic [FLOOR_W-1:0]      r_floor,   w_floor_nxt;
    logic [NUM_FLOORS-1:0]   r_pending, w_pending_nxt;
    logic [c_TRAVEL_W-1:0]   r_travel,  w_travel_nxt;
    logic [c_DOOR_W-1:0]     r_door,    w_door_nxt;

    logic [FLOOR_W-1:0]      w_new_floor;
    logic [NUM_FLOORS-1:0]   w_cur_oh, w_new_oh, w_above_mask, w_below_mask, w_hold_mask;
    logic                    w_pend_above, w_pend_below, w_ahead, w_behind;
    logic                    w_here, w_req_here, w_new_hit;
    logic                    w_travel_done, w_door_done;
    logic [6:0]              w_seg_digit;
    logic                    w_blank;

    assign w_new_floor = r_dir_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));

    always_comb begin
        w_cur_oh     = '0;
        w_new_oh     = '0;
        w_above_mask = '0;
        w_below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_cur_oh[i]     = (r_floor == FLOOR_W'(i));
            w_new_oh[i]     = (w_new_floor == FLOOR_W'(i));
            w_above_mask[i] = (FLOOR_W'(i) > r_floor);
            w_below_mask[i] = (FLOOR_W'(i) < r_floor);
        end
    end

    assign w_pend_above  = |(r_pending & w_above_mask);
    assign w_pend_below  = |(r_pending & w_below_mask);
    assign w_ahead       = r_dir_up ? w_pend_above : w_pend_below;
    assign w_behind      = r_dir_up ? w_pend_below : w_pend_above;
    assign w_here        = |((r_pending | req) & w_cur_oh);
    assign w_req_here    = |(req & w_cur_oh);
    assign w_new_hit     = |((r_pending | req) & w_new_oh);
    assign w_travel_done = (r_travel == c_TRAVEL_W'(TRAVEL_CYCLES - 1));
    assign w_door_done   = (r_door == c_DOOR_W'(DOOR_CYCLES - 1));

    // A call at the car's own floor is served directly unless the car is travelling away.
    assign w_hold_mask = (r_state == ST_MOVE) ? {NUM_FLOORS{1'b0}} : w_cur_oh;

    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir_up;
        w_floor_nxt   = r_floor;
        w_travel_nxt  = r_travel;
        w_door_nxt    = r_door;
        w_pending_nxt = r_pending | (req & ~w_hold_mask);
        case (r_state)
            ST_IDLE: begin
                if (w_here) begin
                    w_state_nxt   = ST_DOOR;
                    w_door_nxt    = '0;
                    w_pending_nxt = w_pending_nxt & ~w_cur_oh;
                end else if (w_ahead) begin
                    w_state_nxt  = ST_MOVE;
                    w_travel_nxt = '0;
                end else if (w_behind) begin
                    w_state_nxt  = ST_MOVE;
                    w_dir_nxt    = ~r_dir_up;
                    w_travel_nxt = '0;
                end
            end
            ST_MOVE: begin
                if (w_travel_done) begin
                    w_travel_nxt = '0;
                    w_floor_nxt  = w_new_floor;
                    if (w_new_hit) begin
                        w_state_nxt   = ST_DOOR;
                        w_door_nxt    = '0;
                        w_pending_nxt = w_pending_nxt & ~w_new_oh;
                    end
                end else begin
                    w_travel_nxt = r_travel + c_TRAVEL_W'(1);
                end
            end
            ST_DOOR: begin
                if (w_req_here) begin
                    w_door_nxt = '0;
                end else if (w_door_done) begin
                    w_door_nxt = '0;
                    if (w_ahead) begin
                        w_state_nxt  = ST_MOVE;
                        w_travel_nxt = '0;
                    end else if (w_behind) begin
                        w_state_nxt  = ST_MOVE;
                        w_dir_nxt    = ~r_dir_up;
                        w_travel_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_door_nxt = r_door + c_DOOR_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_dir_up  <= 1'b1;
            r_floor   <= '0;
            r_pending <= '0;
            r_travel  <= '0;
            r_door    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir_up  <= w_dir_nxt;
            r_floor   <= w_floor_nxt;
            r_pending <= w_pending_nxt;
            r_travel  <= w_travel_nxt;
            r_door    <= w_door_nxt;
        end
    end

    always_comb begin
        w_seg_digit = 7'b0000000;
        case (int'(r_floor))
            0:       w_seg_digit = 7'b1111110;
            1:       w_seg_digit = 7'b0110000;
            2:       w_seg_digit = 7'b1101101;
            3:       w_seg_digit = 7'b1111001;
            4:       w_seg_digit = 7'b0110011;
            5:       w_seg_digit = 7'b1011011;
            6:       w_seg_digit = 7'b1011111;
            7:       w_seg_digit = 7'b1110000;
            8:       w_seg_digit = 7'b1111111;
            9:       w_seg_digit = 7'b1111011;
            default: w_seg_digit = 7'b0000000;
        endcase
    end

`ifdef LIFT_MOVE_BLINK_EN
    assign w_blank = (r_state == ST_MOVE) && (r_travel >= c_TRAVEL_W'(TRAVEL_CYCLES / 2));
`else
    assign w_blank = 1'b0;
`endif

    assign seg       = w_blank ? 7'b0000000 : w_seg_digit;
    assign floor     = r_floor;
    assign pending   = r_pending;
    assign door_open = (r_state == ST_DOOR);
    assign dir_up    = (r_state == ST_MOVE) &&  r_dir_up;
    assign dir_down  = (r_state == ST_MOVE) && !r_dir_up;

endmodule
`default_nettype wire

// File: tb/tb_lift_floor_controller.sv
`default_nettype none
// =============================================================================
// Module   : tb_lift_floor_controller
// Brief    : Directed lift scenarios plus randomized calls against a cycle model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_lift_floor_controller;

    localparam int NF = 8;
    localparam int FW = 4;
    localparam int TC = 4;
    localparam int DC = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] req;
    logic [FW-1:0] floor;
    logic [6:0]    seg;
    logic          dir_up, dir_down, door_open;
    logic [NF-1:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    lift_floor_controller #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .TRAVEL_CYCLES(TC),
        .DOOR_CYCLES  (DC)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .floor    (floor),
        .seg      (seg),
        .dir_up   (dir_up),
        .dir_down (dir_down),
        .door_open(door_open),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // Behavioural car: elapsed travel count per floor, door countdown to closing.
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    int        m_st, m_fl, m_trav, m_door_left;
    bit        m_up;
    bit [NF-1:0] m_pend, m_next;
    bit        m_ahead, m_behind;

    always @(posedge clk) begin
        if (rst) begin
            m_st = M_IDLE; m_fl = 0; m_up = 1'b1; m_pend = '0; m_trav = 0; m_door_left = 0;
        end else begin
            m_next = m_pend;
            for (int i = 0; i < NF; i++)
                if (req[i] && !(i == m_fl && m_st != M_MOVE)) m_next[i] = 1'b1;
            m_ahead = 1'b0; m_behind = 1'b0;
            for (int i = 0; i < NF; i++)
                if (m_pend[i] && i != m_fl) begin
                    if ((i > m_fl) == m_up) m_ahead = 1'b1;
                    else m_behind = 1'b1;
                end
            case (m_st)
                M_IDLE: begin
                    if (req[m_fl] || m_pend[m_fl]) begin
                        m_st = M_DOOR; m_door_left = DC; m_next[m_fl] = 1'b0;
                    end else if (m_ahead) begin
                        m_st = M_MOVE; m_trav = 0;
                    end else if (m_behind) begin
                        m_st = M_MOVE; m_up = !m_up; m_trav = 0;
                    end
                end
                M_MOVE: begin
                    m_trav = m_trav + 1;
                    if (m_trav == TC) begin
                        m_trav = 0;
                        m_fl = m_up ? m_fl + 1 : m_fl - 1;
                        if (m_pend[m_fl] || req[m_fl]) begin
                            m_st = M_DOOR; m_door_left = DC; m_next[m_fl] = 1'b0;
                        end
                    end
                end
                default: begin
                    if (req[m_fl]) m_door_left = DC;
                    else if (m_door_left == 1) begin
                        if (m_ahead) begin
                            m_st = M_MOVE; m_trav = 0;
                        end else if (m_behind) begin
                            m_st = M_MOVE; m_up = !m_up; m_trav = 0;
                        end else m_st = M_IDLE;
                    end else m_door_left = m_door_left - 1;
                end
            endcase
            m_pend = m_next;
        end
    end

    function automatic logic [6:0] exp_seg(input int f, input int st, input int trav);
        logic [6:0] d;
        case (f)
            0: d = 7'b1111110;  1: d = 7'b0110000;  2: d = 7'b1101101;
            3: d = 7'b1111001;  4: d = 7'b0110011;  5: d = 7'b1011011;
            6: d = 7'b1011111;  7: d = 7'b1110000;  8: d = 7'b1111111;
            9: d = 7'b1111011;  default: d = 7'b0000000;
        endcase
`ifdef LIFT_MOVE_BLINK_EN
        if (st == M_MOVE && trav >= TC / 2) d = 7'b0000000;
`endif
        return d;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (floor !== 4'd0) begin n_fail++; $display("FAIL reset_floor got=%0d exp=0", floor); end
        n_checks++; if (seg !== 7'b1111110) begin n_fail++; $display("FAIL reset_seg got=%b exp=1111110", seg); end
        n_checks++; if (door_open !== 1'b0) begin n_fail++; $display("FAIL reset_door got=%b exp=0", door_open); end
        n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got=%h exp=00", pending); end
        n_checks++; if ({dir_up, dir_down} !== 2'b00) begin n_fail++; $display("FAIL reset_dir got=%b exp=00", {dir_up, dir_down}); end
    endtask

    task automatic test_single_trip();
        logic [FW-1:0] fl_t [0:23];
        logic [6:0]    sg_t [0:23];
        logic [NF-1:0] pd_t [0:23];
        logic          up_t [0:23], dn_t [0:23], dr_t [0:23];
        int n_up = 0, n_dn = 0, n_door = 0, first_door = -1;
        req = 8'h08;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            fl_t[i] = floor; sg_t[i] = seg; pd_t[i] = pending;
            up_t[i] = dir_up; dn_t[i] = dir_down; dr_t[i] = door_open;
            req = '0;
        end
        for (int i = 0; i < 24; i++) begin
            n_up += int'(up_t[i]); n_dn += int'(dn_t[i]); n_door += int'(dr_t[i]);
            if (dr_t[i] && first_door < 0) first_door = i;
        end
        n_checks++; if (pd_t[0] !== 8'h08 || up_t[0] !== 1'b0) begin n_fail++; $display("FAIL trip_latch got pend=%h up=%b exp pend=08 up=0", pd_t[0], up_t[0]); end
        n_checks++; if (n_up != 12 || n_dn != 0) begin n_fail++; $display("FAIL trip_up_cycles got up=%0d dn=%0d exp up=12 dn=0", n_up, n_dn); end
        n_checks++; if (fl_t[4] !== 4'd0 || fl_t[5] !== 4'd1 || fl_t[9] !== 4'd2 || fl_t[12] !== 4'd2) begin n_fail++; $display("FAIL trip_steps got %0d,%0d,%0d,%0d exp 0,1,2,2", fl_t[4], fl_t[5], fl_t[9], fl_t[12]); end
        n_checks++; if (first_door != 13 || fl_t[13] !== 4'd3 || sg_t[13] !== 7'b1111001) begin n_fail++; $display("FAIL trip_arrive got idx=%0d fl=%0d seg=%b exp idx=13 fl=3 seg=1111001", first_door, fl_t[13], sg_t[13]); end
        n_checks++; if (n_door != 6) begin n_fail++; $display("FAIL trip_door_len got=%0d exp=6", n_door); end
        n_checks++; if ({up_t[23], dn_t[23], dr_t[23]} !== 3'b000 || pd_t[23] !== 8'h00 || fl_t[23] !== 4'd3) begin n_fail++; $display("FAIL trip_idle got udd=%b pend=%h fl=%0d exp 000 00 3", {up_t[23], dn_t[23], dr_t[23]}, pd_t[23], fl_t[23]); end
    endtask

    task automatic test_reversal();
        logic [FW-1:0] fl_t [0:49];
        logic [NF-1:0] pd_t [0:49];
        logic          up_t [0:49], dn_t [0:49], dr_t [0:49];
        int n_up = 0, n_dn = 0, n_door = 0, n_both = 0;
        req = 8'h40;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            fl_t[i] = floor; pd_t[i] = pending;
            up_t[i] = dir_up; dn_t[i] = dir_down; dr_t[i] = door_open;
            req = (i == 0) ? 8'h02 : 8'h00;
        end
        for (int i = 0; i < 50; i++) begin
            n_up += int'(up_t[i]); n_dn += int'(dn_t[i]); n_door += int'(dr_t[i]);
            n_both += int'(up_t[i] && dn_t[i]);
        end
        n_checks++; if (pd_t[1] !== 8'h42 || up_t[1] !== 1'b1 || fl_t[1] !== 4'd3) begin n_fail++; $display("FAIL rev_start got pend=%h up=%b fl=%0d exp 42 1 3", pd_t[1], up_t[1], fl_t[1]); end
        n_checks++; if (n_up != 12 || n_dn != 20 || n_both != 0) begin n_fail++; $display("FAIL rev_dir_cycles got up=%0d dn=%0d both=%0d exp 12 20 0", n_up, n_dn, n_both); end
        n_checks++; if (fl_t[13] !== 4'd6 || dr_t[13] !== 1'b1 || dn_t[19] !== 1'b1) begin n_fail++; $display("FAIL rev_stop6 got fl=%0d door=%b dn19=%b exp 6 1 1", fl_t[13], dr_t[13], dn_t[19]); end
        n_checks++; if (pd_t[38] !== 8'h02 || pd_t[39] !== 8'h00 || fl_t[39] !== 4'd1 || dr_t[39] !== 1'b1) begin n_fail++; $display("FAIL rev_stop1 got p38=%h p39=%h fl=%0d door=%b exp 02 00 1 1", pd_t[38], pd_t[39], fl_t[39], dr_t[39]); end
        n_checks++; if (n_door != 12 || {up_t[49], dn_t[49], dr_t[49]} !== 3'b000) begin n_fail++; $display("FAIL rev_end got doors=%0d udd=%b exp 12 000", n_door, {up_t[49], dn_t[49], dr_t[49]}); end
    endtask

    task automatic test_door_hold();
        bit found = 1'b0;
        int cnt;
        req = 8'h04;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            req = '0;
            found = door_open;
        end
        n_checks++; if (!found || floor !== 4'd2) begin n_fail++; $display("FAIL hold_arrive got door=%b fl=%0d exp 1 2", found, floor); end
        req = 8'h04;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++; if (door_open !== 1'b1 || pending !== 8'h00) begin n_fail++; $display("FAIL hold_door k=%0d got door=%b pend=%h exp 1 00", k, door_open, pending); end
        end
        req = '0;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!door_open) break;
            cnt++;
        end
        n_checks++; if (cnt != 6 || door_open !== 1'b0 || dir_up !== 1'b0 || dir_down !== 1'b0) begin n_fail++; $display("FAIL hold_release got cycles=%0d door=%b exp 6 0", cnt, door_open); end
    endtask

    task automatic test_reset_mid_move();
        bit found = 1'b0;
        req = 8'h80;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            req = '0;
            found = (floor == 4'd4);
        end
        repeat (2) @(negedge clk);
        n_checks++; if (!found || dir_up !== 1'b1 || floor !== 4'd4) begin n_fail++; $display("FAIL rstmove_pre got found=%b up=%b fl=%0d exp 1 1 4", found, dir_up, floor); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (floor !== 4'd0 || pending !== 8'h00 || seg !== 7'b1111110 || {dir_up, dir_down, door_open} !== 3'b000) begin
            n_fail++; $display("FAIL rstmove_post got fl=%0d pend=%h seg=%b udd=%b exp 0 00 1111110 000", floor, pending, seg, {dir_up, dir_down, door_open});
        end
        @(negedge clk);
        n_checks++; if (floor !== 4'd0 || {dir_up, dir_down, door_open} !== 3'b000) begin n_fail++; $display("FAIL rstmove_idle got fl=%0d udd=%b exp 0 000", floor, {dir_up, dir_down, door_open}); end
    endtask

`ifdef LIFT_MOVE_BLINK_EN
    task automatic test_blink();
        logic [6:0] sg_t [0:7];
        req = 8'h02;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sg_t[i] = seg;
            req = '0;
        end
        n_checks++; if (sg_t[1] !== 7'b1111110 || sg_t[2] !== 7'b1111110) begin n_fail++; $display("FAIL blink_on got %b %b exp 1111110", sg_t[1], sg_t[2]); end
        n_checks++; if (sg_t[3] !== 7'b0000000 || sg_t[4] !== 7'b0000000) begin n_fail++; $display("FAIL blink_off got %b %b exp 0000000", sg_t[3], sg_t[4]); end
        n_checks++; if (sg_t[5] !== 7'b0110000) begin n_fail++; $display("FAIL blink_arrive got %b exp 0110000", sg_t[5]); end
        repeat (8) @(negedge clk);
    endtask
`endif

    task automatic test_random(input int n);
        logic [FW-1:0] e_fl;
        logic [6:0]    e_seg;
        logic [2:0]    e_udd;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e_fl  = FW'(m_fl);
            e_seg = exp_seg(m_fl, m_st, m_trav);
            e_udd = {m_st == M_MOVE && m_up, m_st == M_MOVE && !m_up, m_st == M_DOOR};
            n_checks++;
            if ({floor, seg, dir_up, dir_down, door_open, pending} !== {e_fl, e_seg, e_udd, m_pend}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got fl=%0d seg=%b udd=%b pend=%h exp fl=%0d seg=%b udd=%b pend=%h",
                         k, floor, seg, {dir_up, dir_down, door_open}, pending, e_fl, e_seg, e_udd, m_pend);
            end
            rst = ($urandom_range(0, 499) == 0);
            case ($urandom_range(0, 9))
                0, 1:    req = NF'(1) << $urandom_range(0, NF - 1);
                2:       req = req;
                default: req = '0;
            endcase
        end
        rst = 1'b0;
        req = '0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        test_reset();
        test_single_trip();
        test_reversal();
        test_door_hold();
        test_reset_mid_move();
`ifdef LIFT_MOVE_BLINK_EN
        test_blink();
`endif
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
